// File: rtl/sb_txn_pkg.sv
// Shared types and codes for the sideband register transaction controller.
package sb_txn_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        FIN      = 2'd3
    } state_e;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Counter width able to hold 0..n-1, never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sb_txn_timer.sv
// Response timeout counter: cleared on request acceptance, counts while
// enabled and saturates at LIMIT-1, where it flags expiry.
module sb_txn_timer
    import sb_txn_pkg::*;
#(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CW   = cnt_w(LIMIT);
    localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    // Count up while enabled; hold at LAST so the counter never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  cnt_q <= '0;
        else if (clr)                  cnt_q <= '0;
        else if (en && cnt_q != LAST)  cnt_q <= cnt_q + 1'b1;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/sb_reg_txn_ctrl.sv
// Sideband register transaction controller: one read/write in flight,
// retry on error or timeout, single-cycle done with status and read data.
module sb_reg_txn_ctrl
    import sb_txn_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_read_pul,
    input  logic              s_write_pul,
    input  logic              trans_error_pul,
    input  logic              t_valid_pul,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_ack,
    output logic              tx_req,
    output logic              tx_cmd,
    output logic [ADDR_W-1:0] tx_addr,
    output logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [1:0]        status,
    output logic              busy
);

    localparam int            RW   = cnt_w(MAX_RETRY + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    state_e            state_q, state_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        status_q, status_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              tmo_exp;

    // Timer restarts when the transmitter takes the request, so every
    // attempt gets a full TIMEOUT_CYC window in WAIT_RSP.
    sb_txn_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == SEND && tx_ack),
        .en      (state_q == WAIT_RSP),
        .expired (tmo_exp)
    );

    // State and latched transaction fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= ST_OK;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            retry_q  <= retry_d;
        end
    end

    // Next state: commands only accepted in IDLE, responses only in WAIT_RSP;
    // an error pulse outranks both a valid pulse and a timeout.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        retry_d  = retry_q;
        case (state_q)
            IDLE: begin
                if (s_write_pul) begin
                    cmd_d   = CMD_WR;
                    addr_d  = addr;
                    wdata_d = wdata;
                    retry_d = '0;
                    state_d = SEND;
                end else if (s_read_pul) begin
                    cmd_d   = CMD_RD;
                    addr_d  = addr;
                    retry_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ack) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (trans_error_pul || tmo_exp) begin
                    if (retry_q < RMAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = SEND;
                    end else begin
                        status_d = trans_error_pul ? ST_ERR : ST_TMO;
                        state_d  = FIN;
                    end
                end else if (t_valid_pul) begin
                    status_d = ST_OK;
                    if (cmd_q == CMD_RD) rdata_d = rx_data;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        tx_req = (state_q == SEND);
        done   = (state_q == FIN);
        busy   = (state_q != IDLE);
    end

    assign tx_cmd  = cmd_q;
    assign tx_addr = addr_q;
    assign tx_data = wdata_q;
    assign rdata   = rdata_q;
    assign status  = status_q;

endmodule

// File: tb/tb_sb_reg_txn_ctrl.sv
// Directed bench for sb_reg_txn_ctrl with TIMEOUT_CYC=16, MAX_RETRY=3.
module tb_sb_reg_txn_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_read_pul = 1'b0, s_write_pul = 1'b0;
    logic        trans_error_pul = 1'b0, t_valid_pul = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0, rx_data = '0;
    logic        tx_ack = 1'b0;
    logic        tx_req, tx_cmd, done, busy;
    logic [7:0]  tx_addr;
    logic [31:0] tx_data, rdata;
    logic [1:0]  status;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    logic req_prev = 1'b0;
    int r0, d0;

    sb_reg_txn_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_read_pul(s_read_pul), .s_write_pul(s_write_pul),
        .trans_error_pul(trans_error_pul), .t_valid_pul(t_valid_pul),
        .addr(addr), .wdata(wdata), .rx_data(rx_data), .tx_ack(tx_ack),
        .tx_req(tx_req), .tx_cmd(tx_cmd), .tx_addr(tx_addr), .tx_data(tx_data),
        .rdata(rdata), .done(done), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count request sequences (rising edges of tx_req) and done pulses.
    always @(posedge clk) begin
        if (tx_req && !req_prev) req_cnt++;
        req_prev = tx_req;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d);
        s_write_pul = wr; s_read_pul = rd; addr = a; wdata = d;
        step();
        s_write_pul = 1'b0; s_read_pul = 1'b0;
    endtask

    task automatic ack();
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
    endtask

    task automatic rsp(input logic v, input logic e, input logic [31:0] d);
        t_valid_pul = v; trans_error_pul = e; rx_data = d;
        step();
        t_valid_pul = 1'b0; trans_error_pul = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_rdata",  rdata, 0);
        chk("rst_tx_addr", 32'(tx_addr), 0);
        chk("rst_tx_data", tx_data, 0);
        reset_n = 1'b1;
        step();

        // 1: write; SEND holds and ignores responses until ack
        cmd(1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
        chk("t1_tx_req", 32'(tx_req), 1);
        chk("t1_tx_cmd", 32'(tx_cmd), 1);
        chk("t1_tx_addr", 32'(tx_addr), 32'h10);
        chk("t1_tx_data", tx_data, 32'hDEADBEEF);
        chk("t1_busy", 32'(busy), 1);
        rsp(1'b1, 1'b0, 32'h0BAD0BAD);
        chk("t1_send_hold", 32'(tx_req), 1);
        chk("t1_send_nodone", 32'(done), 0);
        ack();
        chk("t1_req_drop", 32'(tx_req), 0);
        chk("t1_wait_busy", 32'(busy), 1);
        rsp(1'b1, 1'b0, 32'h55555555);
        chk("t1_done", 32'(done), 1);
        chk("t1_status", 32'(status), 0);
        chk("t1_rdata", rdata, 0);
        step();
        chk("t1_done_1cyc", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);

        // 2: read, extra commands while busy are ignored
        r0 = req_cnt;
        cmd(1'b0, 1'b1, 8'h2A, 32'h0);
        chk("t2_tx_cmd", 32'(tx_cmd), 0);
        chk("t2_tx_addr", 32'(tx_addr), 32'h2A);
        cmd(1'b0, 1'b1, 8'h55, 32'h0);
        chk("t2_addr_kept", 32'(tx_addr), 32'h2A);
        ack();
        cmd(1'b0, 1'b1, 8'h66, 32'h0);
        rsp(1'b1, 1'b0, 32'h12345678);
        chk("t2_done", 32'(done), 1);
        chk("t2_status", 32'(status), 0);
        chk("t2_rdata", rdata, 32'h12345678);
        cmd(1'b0, 1'b1, 8'h77, 32'h0);
        chk("t2_fin_cmd_ignored", 32'(busy), 0);
        step();
        chk("t2_req_count", 32'(req_cnt - r0), 1);

        // 3a: two errors then success -> three requests
        r0 = req_cnt;
        cmd(1'b0, 1'b1, 8'h31, 32'h0);
        for (int i = 0; i < 2; i++) begin
            ack();
            rsp(1'b0, 1'b1, 32'h0);
            chk("t3_retry_req", 32'(tx_req), 1);
        end
        chk("t3_addr_kept", 32'(tx_addr), 32'h31);
        ack();
        rsp(1'b1, 1'b0, 32'hA0B1C2D3);
        chk("t3_done", 32'(done), 1);
        chk("t3_status_ok", 32'(status), 0);
        chk("t3_rdata", rdata, 32'hA0B1C2D3);
        chk("t3_req_count", 32'(req_cnt - r0), 3);
        step();

        // 3b: four errors -> four requests, status ERROR
        r0 = req_cnt;
        cmd(1'b0, 1'b1, 8'h32, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ack();
            rsp(1'b0, 1'b1, 32'h0);
        end
        chk("t3b_done", 32'(done), 1);
        chk("t3b_status_err", 32'(status), 1);
        chk("t3b_rdata_kept", rdata, 32'hA0B1C2D3);
        chk("t3b_req_count", 32'(req_cnt - r0), 4);
        step();

        // 4: no response -> retry after 16 WAIT cycles, timeout after 4 attempts
        r0 = req_cnt;
        cmd(1'b0, 1'b1, 8'h40, 32'h0);
        for (int a = 1; a <= 4; a++) begin
            ack();
            for (int c = 0; c < 15; c++) step();
            chk("t4_still_waiting", 32'(tx_req | done), 0);
            step();
            if (a < 4) chk("t4_retry_req", 32'(tx_req), 1);
        end
        chk("t4_done", 32'(done), 1);
        chk("t4_status_tmo", 32'(status), 2);
        chk("t4_req_count", 32'(req_cnt - r0), 4);
        step();

        // 5: simultaneous read+write -> write; valid+error -> retry
        r0 = req_cnt; d0 = done_cnt;
        cmd(1'b1, 1'b1, 8'h33, 32'hCAFEF00D);
        chk("t5_tx_cmd_wr", 32'(tx_cmd), 1);
        chk("t5_tx_data", tx_data, 32'hCAFEF00D);
        ack();
        rsp(1'b1, 1'b1, 32'h11111111);
        chk("t5_err_wins", 32'(tx_req), 1);
        chk("t5_no_done", 32'(done), 0);
        ack();
        rsp(1'b1, 1'b0, 32'h22222222);
        chk("t5_done", 32'(done), 1);
        chk("t5_status", 32'(status), 0);
        chk("t5_rdata_kept", rdata, 32'hA0B1C2D3);
        step();
        chk("t5_req_count", 32'(req_cnt - r0), 2);
        chk("t5_done_count", 32'(done_cnt - d0), 1);

        // 6: reset mid-transaction aborts asynchronously
        cmd(1'b0, 1'b1, 8'h50, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_send_req_async", 32'(tx_req), 0);
        chk("t6_send_busy_async", 32'(busy), 0);
        step();
        reset_n = 1'b1;
        step();
        cmd(1'b0, 1'b1, 8'h51, 32'h0);
        ack();
        step();
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_wait_req", 32'(tx_req), 0);
        chk("t6_wait_busy", 32'(busy), 0);
        chk("t6_wait_done", 32'(done), 0);
        chk("t6_rdata_rst", rdata, 0);
        step(); step(); step();
        reset_n = 1'b1;
        step(); step();
        chk("t6_no_done", 32'(done_cnt - d0), 0);
        cmd(1'b0, 1'b1, 8'h44, 32'h0);
        chk("t6_new_addr", 32'(tx_addr), 32'h44);
        ack();
        rsp(1'b1, 1'b0, 32'hA5A5A5A5);
        chk("t6_done", 32'(done), 1);
        chk("t6_status", 32'(status), 0);
        chk("t6_rdata", rdata, 32'hA5A5A5A5);
        step();
        chk("t6_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
